// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
package cpu_mem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_IF   = 1'b0,
      PORT_DATA = 1'b1
   } port_e;

   // Pick the port to serve from IDLE; ties go to data, or alternate when rr is set.
   function automatic port_e pick_port(input logic if_req, input logic mem_req,
                                       input logic rr, input port_e last);
      if (if_req && !mem_req) return PORT_IF;
      if (!if_req && mem_req) return PORT_DATA;
      if (rr) return (last == PORT_IF) ? PORT_DATA : PORT_IF;
      return PORT_DATA;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline fetch/data ports plus the shared single-port RAM port.
interface unified_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 10
);
   // fetch port
   logic                  if_req;
   logic [31:0]           if_pc;
   logic [31:0]           if_inst;
   logic                  if_ready;
   // data port
   logic                  mem_req;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_ready;
   // RAM port
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;
   // pipeline hold
   logic                  stall;

   // Pipeline and RAM side
   modport master (
      output if_req, if_pc, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_inst, if_ready, mem_rdata, mem_ready,
             ram_en, ram_we, ram_addr, ram_wdata, stall
   );

   // Arbiter side
   modport slave (
      input  if_req, if_pc, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_inst, if_ready, mem_rdata, mem_ready,
             ram_en, ram_we, ram_addr, ram_wdata, stall
   );
endinterface

// File: rtl/wait_state_counter.sv
// Down-counter holding the remaining wait states of the current RAM access.
module wait_state_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero_c
);

   logic [WIDTH-1:0] cnt;

   // Load on grant, count down while the access window is open, saturate at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one single-port RAM.
module unified_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned ROUND_ROBIN = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   unified_mem_arbiter_if.slave bus
);

   localparam int unsigned AW  = ADDR_WIDTH;
   localparam int unsigned OFS = $clog2(WORD_BYTES);

   state_e            state, state_n;
   port_e             grant, grant_n;
   port_e             last_grant, last_grant_n;
   logic              ram_en_n, ram_we_n;
   logic [AW-1:0]     ram_addr_n;
   logic [DATA_W-1:0] ram_wdata_n, if_inst_n, mem_rdata_n;
   logic              if_ready_n, mem_ready_n;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic              unused_bits;

   // Byte-offset and high address bits carry no meaning for the word RAM.
   assign unused_bits = ^{bus.if_pc, bus.mem_addr};

   wait_state_counter #(.WIDTH(CNT_W)) u_wait (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (CNT_W'(WAIT_CYCLES)),
      .zero_c   (cnt_zero)
   );

   // Pipeline hold: any request still outstanding.
   assign bus.stall = (bus.if_req & ~bus.if_ready) | (bus.mem_req & ~bus.mem_ready);

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      ram_en_n     = bus.ram_en;
      ram_we_n     = bus.ram_we;
      ram_addr_n   = bus.ram_addr;
      ram_wdata_n  = bus.ram_wdata;
      if_inst_n    = bus.if_inst;
      mem_rdata_n  = bus.mem_rdata;
      if_ready_n   = 1'b0;
      mem_ready_n  = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.if_req || bus.mem_req) begin
               grant_n  = pick_port(bus.if_req, bus.mem_req, (ROUND_ROBIN != 0), last_grant);
               state_n  = ACCESS;
               ram_en_n = 1'b1;
               cnt_load = 1'b1;
               if (grant_n == PORT_DATA) begin
                  ram_we_n    = bus.mem_we;
                  ram_addr_n  = bus.mem_addr[AW+OFS-1:OFS];
                  ram_wdata_n = bus.mem_wdata;
               end else begin
                  ram_we_n    = 1'b0;
                  ram_addr_n  = bus.if_pc[AW+OFS-1:OFS];
               end
            end
         end
         ACCESS: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               if (grant == PORT_IF) begin
                  if_inst_n  = bus.ram_rdata;
                  if_ready_n = 1'b1;
               end else begin
                  if (!bus.ram_we) mem_rdata_n = bus.ram_rdata;
                  mem_ready_n = 1'b1;
               end
               ram_en_n     = 1'b0;
               ram_we_n     = 1'b0;
               last_grant_n = grant;
               state_n      = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops the RAM strobe without waiting for a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         grant         <= PORT_IF;
         last_grant    <= PORT_IF;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.if_inst   <= '0;
         bus.mem_rdata <= '0;
         bus.if_ready  <= 1'b0;
         bus.mem_ready <= 1'b0;
      end else begin
         state         <= state_n;
         grant         <= grant_n;
         last_grant    <= last_grant_n;
         bus.ram_en    <= ram_en_n;
         bus.ram_we    <= ram_we_n;
         bus.ram_addr  <= ram_addr_n;
         bus.ram_wdata <= ram_wdata_n;
         bus.if_inst   <= if_inst_n;
         bus.mem_rdata <= mem_rdata_n;
         bus.if_ready  <= if_ready_n;
         bus.mem_ready <= mem_ready_n;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: three instances cover W=0, W=2 and W=3 round-robin.
module tb_unified_mem_arbiter;
   import cpu_mem_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;

   unified_mem_arbiter_if #(.ADDR_WIDTH(10)) ifa ();
   unified_mem_arbiter_if #(.ADDR_WIDTH(10)) ifb ();
   unified_mem_arbiter_if #(.ADDR_WIDTH(10)) ifc ();

   unified_mem_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .ROUND_ROBIN(0))
      u_a (.clock(clock), .reset(reset), .bus(ifa));
   unified_mem_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .ROUND_ROBIN(0))
      u_b (.clock(clock), .reset(reset), .bus(ifb));
   unified_mem_arbiter #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .ROUND_ROBIN(1))
      u_c (.clock(clock), .reset(reset), .bus(ifc));

   // Preloaded RAM contents; written words override these.
   function automatic logic [31:0] init_word(input logic [9:0] a);
      case (a)
         10'h010: return 32'h2008_000A;
         10'h011: return 32'h3333_4444;
         10'h080: return 32'h1111_2222;
         default: return {22'h0, a} ^ 32'hA5A5_0000;
      endcase
   endfunction

   logic [31:0]   wr_a [0:1023];
   logic [31:0]   wr_b [0:1023];
   logic [31:0]   wr_c [0:1023];
   logic [1023:0] wv_a, wv_b, wv_c;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         wv_a <= '0; wv_b <= '0; wv_c <= '0;
      end else begin
         if (ifa.ram_en && ifa.ram_we) begin wv_a[ifa.ram_addr] <= 1'b1; wr_a[ifa.ram_addr] <= ifa.ram_wdata; end
         if (ifb.ram_en && ifb.ram_we) begin wv_b[ifb.ram_addr] <= 1'b1; wr_b[ifb.ram_addr] <= ifb.ram_wdata; end
         if (ifc.ram_en && ifc.ram_we) begin wv_c[ifc.ram_addr] <= 1'b1; wr_c[ifc.ram_addr] <= ifc.ram_wdata; end
      end
   end

   assign ifa.ram_rdata = wv_a[ifa.ram_addr] ? wr_a[ifa.ram_addr] : init_word(ifa.ram_addr);
   assign ifb.ram_rdata = wv_b[ifb.ram_addr] ? wr_b[ifb.ram_addr] : init_word(ifb.ram_addr);
   assign ifc.ram_rdata = wv_c[ifc.ram_addr] ? wr_c[ifc.ram_addr] : init_word(ifc.ram_addr);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      ifa.if_req = 0; ifa.if_pc = 0; ifa.mem_req = 0; ifa.mem_we = 0; ifa.mem_addr = 0; ifa.mem_wdata = 0;
      ifb.if_req = 0; ifb.if_pc = 0; ifb.mem_req = 0; ifb.mem_we = 0; ifb.mem_addr = 0; ifb.mem_wdata = 0;
      ifc.if_req = 0; ifc.if_pc = 0; ifc.mem_req = 0; ifc.mem_we = 0; ifc.mem_addr = 0; ifc.mem_wdata = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if ({ifa.if_ready, ifa.mem_ready, ifa.ram_en, ifa.ram_we, ifa.stall} !== 5'b0)
         $display("FAIL reset_flags: got %b, expected 00000",
                  {ifa.if_ready, ifa.mem_ready, ifa.ram_en, ifa.ram_we, ifa.stall});
      else n_pass++;
      n_checks++;
      if ({ifa.ram_addr, ifa.ram_wdata} !== 42'h0)
         $display("FAIL reset_ram_bus: got %h, expected 0", {ifa.ram_addr, ifa.ram_wdata});
      else n_pass++;
      n_checks++;
      if ({ifa.if_inst, ifa.mem_rdata} !== 64'h0)
         $display("FAIL reset_data: got %h, expected 0", {ifa.if_inst, ifa.mem_rdata});
      else n_pass++;
      n_checks++;
      if (u_a.state !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", u_a.state, IDLE);
      else n_pass++;
   endtask

   // Single fetch with no wait states.
   task automatic test_fetch();
      ifa.if_pc  = 32'h40;
      ifa.if_req = 1'b1;
      tick();
      n_checks++;
      if ({ifa.ram_en, ifa.ram_we, ifa.if_ready, ifa.stall, ifa.ram_addr} !== {4'b1001, 10'h010})
         $display("FAIL fetch_access: got %b/%h, expected 1001/010",
                  {ifa.ram_en, ifa.ram_we, ifa.if_ready, ifa.stall}, ifa.ram_addr);
      else n_pass++;
      tick();
      n_checks++;
      if ({ifa.if_ready, ifa.stall, ifa.ram_en} !== 3'b100)
         $display("FAIL fetch_ready: got %b, expected 100", {ifa.if_ready, ifa.stall, ifa.ram_en});
      else n_pass++;
      n_checks++;
      if (ifa.if_inst !== 32'h2008_000A)
         $display("FAIL fetch_inst: got %h, expected 2008000a", ifa.if_inst);
      else n_pass++;
      ifa.if_req = 1'b0;
      tick();
      n_checks++;
      if ({ifa.if_ready, ifa.if_inst} !== {1'b0, 32'h2008_000A})
         $display("FAIL fetch_hold: got %b/%h, expected 0/2008000a", ifa.if_ready, ifa.if_inst);
      else n_pass++;
   endtask

   // Store then load through the W=2 instance, with junk address bits on the load.
   task automatic test_store_load();
      int en_cnt;
      int rdy_edge;
      bit we_ok;
      en_cnt = 0; rdy_edge = -1; we_ok = 1'b1;
      ifb.mem_we = 1'b1; ifb.mem_addr = 32'h100; ifb.mem_wdata = 32'hDEAD_BEEF; ifb.mem_req = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (ifb.ram_en) begin en_cnt++; if (!ifb.ram_we) we_ok = 1'b0; end
         if (ifb.mem_ready && rdy_edge < 0) begin rdy_edge = e; ifb.mem_req = 1'b0; end
      end
      n_checks++;
      if (en_cnt != 3 || !we_ok) $display("FAIL store_window: got %0d cycles we_ok=%0d, expected 3/1", en_cnt, we_ok);
      else n_pass++;
      n_checks++;
      if (rdy_edge != 3) $display("FAIL store_latency: got edge %0d, expected 3", rdy_edge);
      else n_pass++;
      n_checks++;
      if (ifb.mem_rdata !== 32'h0) $display("FAIL store_rdata_kept: got %h, expected 0", ifb.mem_rdata);
      else n_pass++;

      rdy_edge = -1;
      ifb.mem_we = 1'b0; ifb.mem_addr = 32'hABC0_0101; ifb.mem_req = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (ifb.mem_ready && rdy_edge < 0) begin
            rdy_edge = e;
            n_checks++;
            if (ifb.mem_rdata !== 32'hDEAD_BEEF) $display("FAIL load_data: got %h, expected deadbeef", ifb.mem_rdata);
            else n_pass++;
            ifb.mem_req = 1'b0;
         end
      end
      n_checks++;
      if (rdy_edge != 3) $display("FAIL load_latency: got edge %0d, expected 3", rdy_edge);
      else n_pass++;
   endtask

   // Simultaneous fetch and load with data priority.
   task automatic test_contention();
      int m_edge;
      int f_edge;
      bit stall_ok;
      bit both;
      m_edge = -1; f_edge = -1; stall_ok = 1'b1; both = 1'b0;
      ifa.if_pc = 32'h44; ifa.mem_we = 1'b0; ifa.mem_addr = 32'h200;
      ifa.if_req = 1'b1; ifa.mem_req = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (ifa.if_ready && ifa.mem_ready) both = 1'b1;
         if (f_edge < 0 && !ifa.if_ready && ifa.stall !== 1'b1) stall_ok = 1'b0;
         if (ifa.mem_ready && m_edge < 0) begin m_edge = e; ifa.mem_req = 1'b0; end
         if (ifa.if_ready && f_edge < 0) begin f_edge = e; ifa.if_req = 1'b0; end
      end
      n_checks++;
      if (m_edge != 1 || f_edge != 4)
         $display("FAIL contention_order: got data %0d fetch %0d, expected 1/4", m_edge, f_edge);
      else n_pass++;
      n_checks++;
      if (!stall_ok || both) $display("FAIL contention_stall: got stall_ok=%0d both=%0d, expected 1/0", stall_ok, both);
      else n_pass++;
      n_checks++;
      if ({ifa.mem_rdata, ifa.if_inst} !== {32'h1111_2222, 32'h3333_4444})
         $display("FAIL contention_data: got %h/%h, expected 11112222/33334444", ifa.mem_rdata, ifa.if_inst);
      else n_pass++;
   endtask

   // Held request: one pulse per grant, each new access starts from IDLE.
   task automatic test_back_to_back();
      logic [11:0] rdy_mask;
      logic [11:0] en_mask;
      rdy_mask = '0; en_mask = '0;
      ifa.if_pc = 32'h40; ifa.if_req = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         rdy_mask[e] = ifa.if_ready;
         en_mask[e]  = ifa.ram_en;
      end
      ifa.if_req = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (rdy_mask !== 12'h492) $display("FAIL b2b_ready: got %h, expected 492", rdy_mask);
      else n_pass++;
      n_checks++;
      if (en_mask !== 12'h249) $display("FAIL b2b_ram_en: got %h, expected 249", en_mask);
      else n_pass++;
   endtask

   // Reset asserted between clock edges in the second cycle of a W=3 store.
   task automatic test_reset_abort();
      int rdy_seen;
      int en_seen;
      rdy_seen = 0; en_seen = 0;
      ifc.mem_we = 1'b1; ifc.mem_addr = 32'h300; ifc.mem_wdata = 32'h1234_5678; ifc.mem_req = 1'b1;
      tick();
      n_checks++;
      if ({ifc.ram_en, ifc.ram_we} !== 2'b11) $display("FAIL abort_start: got %b, expected 11", {ifc.ram_en, ifc.ram_we});
      else n_pass++;
      tick();
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({ifc.ram_en, ifc.ram_we, ifc.mem_ready} !== 3'b000)
         $display("FAIL abort_async: got %b, expected 000", {ifc.ram_en, ifc.ram_we, ifc.mem_ready});
      else n_pass++;
      ifc.mem_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (ifc.mem_ready) rdy_seen++;
         if (ifc.ram_en) en_seen++;
      end
      n_checks++;
      if (rdy_seen != 0 || en_seen != 0)
         $display("FAIL abort_quiet: got ready %0d en %0d, expected 0/0", rdy_seen, en_seen);
      else n_pass++;
      n_checks++;
      if (u_c.state !== IDLE) $display("FAIL abort_state: got %0d, expected %0d", u_c.state, IDLE);
      else n_pass++;
   endtask

   // Round-robin with both requests held: grants alternate starting with data.
   task automatic test_round_robin();
      int g [4];
      int ng;
      int last_e;
      ng = 0; last_e = -1;
      ifc.if_pc = 32'h48; ifc.mem_we = 1'b0; ifc.mem_addr = 32'h304;
      ifc.if_req = 1'b1; ifc.mem_req = 1'b1;
      for (int e = 0; e < 40 && ng < 4; e++) begin
         tick();
         if (ifc.if_ready && ifc.mem_ready) begin
            n_checks++;
            $display("FAIL rr_both_ready: got both at edge %0d, expected one", e);
         end
         if (ifc.if_ready) begin g[ng] = 0; ng++; last_e = e; end
         else if (ifc.mem_ready) begin g[ng] = 1; ng++; last_e = e; end
      end
      ifc.if_req = 1'b0; ifc.mem_req = 1'b0;
      n_checks++;
      if (ng != 4 || last_e != 22) $display("FAIL rr_count: got %0d grants last edge %0d, expected 4/22", ng, last_e);
      else n_pass++;
      for (int i = 0; i < ng; i++) begin
         n_checks++;
         if (g[i] != ((i % 2 == 0) ? 1 : 0))
            $display("FAIL rr_grant%0d: got %0d, expected %0d", i, g[i], (i % 2 == 0) ? 1 : 0);
         else n_pass++;
      end
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_back_to_back();
      test_reset_abort();
      test_round_robin();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
